logic_unit_seq: RTL and testbench

//  Parametrised, multi-cycle bitwise logic unit for the ALU; successor to the fixed
//  32-bit OR gate. Selectable op (OR/AND/XOR/NOR/NAND/XNOR/ANDN). Processes operands

---
 rtl/logic_unit_seq.sv | 128 ++++++++++++
 tb/tb_logic_unit_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: latches operands, then evaluates CHUNK bits per cycle LSB-first.
// state | meaning: IDLE accepting operands | BUSY writing one slice per cycle | DONE result held for consumer
module logic_unit_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             err_o
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             zero_q;
   logic             err_q;
   logic [2:0]       op_q;
   logic [IDXW-1:0]  idx_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;

   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK-1:0] slice_d;
   logic [WIDTH-1:0] result_d;
   logic             last_slice;

   always_comb begin
      a_slice = a_q[idx_q*CHUNK +: CHUNK];
      b_slice = b_q[idx_q*CHUNK +: CHUNK];
      slice_d = '0;
      case (op_q)
         3'b000:  slice_d = a_slice | b_slice;
         3'b001:  slice_d = a_slice & b_slice;
         3'b010:  slice_d = a_slice ^ b_slice;
         3'b011:  slice_d = ~(a_slice | b_slice);
         3'b100:  slice_d = ~(a_slice & b_slice);
         3'b101:  slice_d = ~(a_slice ^ b_slice);
         3'b110:  slice_d = a_slice & ~b_slice;
         default: slice_d = '0;
      endcase
      result_d = result_q;
      result_d[idx_q*CHUNK +: CHUNK] = slice_d;
      last_slice = (idx_q == IDXW'(NCHUNK - 1));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         op_q        <= '0;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid_i && in_ready_q) begin
                  a_q        <= a_i;
                  b_q        <= b_i;
                  op_q       <= op_i;
                  idx_q      <= '0;
                  result_q   <= '0;
                  zero_q     <= 1'b0;
                  err_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               result_q <= result_d;
               if (last_slice) begin
                  // zero looks at the whole word including the slice written this edge
                  idx_q       <= '0;
                  zero_q      <= (result_d == '0);
                  err_q       <= (op_q == 3'b111);
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  idx_q <= idx_q + IDXW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign zero_o      = zero_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: directed and random ops on a CHUNK=8 and a CHUNK=32 instance,
// checked against a whole-word reference model.
module tb_logic_unit_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         out_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   int           sel;
   int           nchunk;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   logic         iv8, iv32, or8, or32;
   logic         ir8, ir32, ov8, ov32, z8, z32, e8, e32;
   logic [W-1:0] r8, r32;
   logic         in_ready_m, out_valid_m, zero_m, err_m;
   logic [W-1:0] result_m;

   assign iv8  = in_valid  & (sel == 0);
   assign iv32 = in_valid  & (sel == 1);
   assign or8  = out_ready & (sel == 0);
   assign or32 = out_ready & (sel == 1);

   assign in_ready_m  = (sel == 0) ? ir8 : ir32;
   assign out_valid_m = (sel == 0) ? ov8 : ov32;
   assign result_m    = (sel == 0) ? r8  : r32;
   assign zero_m      = (sel == 0) ? z8  : z32;
   assign err_m       = (sel == 0) ? e8  : e32;

   logic_unit_seq #(.WIDTH(W), .CHUNK(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv8), .in_ready_o(ir8), .op_i(op),
      .a_i(a), .b_i(b), .out_valid_o(ov8), .out_ready_i(or8), .result_o(r8),
      .zero_o(z8), .err_o(e8)
   );

   logic_unit_seq #(.WIDTH(W), .CHUNK(32)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv32), .in_ready_o(ir32), .op_i(op),
      .a_i(a), .b_i(b), .out_valid_o(ov32), .out_ready_i(or32), .result_o(r32),
      .zero_o(z32), .err_o(e32)
   );

   function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      case (o)
         3'd0:    return x | y;
         3'd1:    return x & y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x | y);
         3'd4:    return ~(x & y);
         3'd5:    return ~(x ^ y);
         3'd6:    return x & ~y;
         default: return '0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (chunk_inst=%0d)", tag, obs, exp, sel);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full transaction; hold = cycles to keep out_ready low with noise on the inputs.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input int hold);
      int           n;
      logic [W-1:0] exp;
      exp = model(o, xa, xb);
      n = 0;
      while (!in_ready_m && n < 50) begin
         step();
         n++;
      end
      check("in_ready_idle", 64'(in_ready_m), 64'd1);
      op = o; a = xa; b = xb; in_valid = 1'b1;
      step();
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
      check("in_ready_after_accept", 64'(in_ready_m), 64'd0);
      n = 0;
      while (!out_valid_m && n < 50) begin
         step();
         n++;
      end
      check("latency", 64'(n), 64'(nchunk));
      check("result", 64'(result_m), 64'(exp));
      check("zero", 64'(zero_m), 64'(exp == '0));
      check("err", 64'(err_m), 64'(o == 3'b111));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; op = 3'($urandom);
         step();
         check("hold_result", 64'(result_m), 64'(exp));
         check("hold_valid_ready", {62'd0, out_valid_m, in_ready_m}, 64'b10);
      end
      // handoff with a competing request: only the handoff may happen on this edge
      out_ready = 1'b1; in_valid = 1'b1;
      step();
      out_ready = 1'b0; in_valid = 1'b0;
      check("handoff_valid_ready", {62'd0, out_valid_m, in_ready_m}, 64'b01);
   endtask

   task automatic check_reset_state;
      check("rst_ready_valid", {62'd0, in_ready_m, out_valid_m}, 64'b10);
      check("rst_result", 64'(result_m), 64'd0);
      check("rst_flags", {62'd0, zero_m, err_m}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      sel = 0; nchunk = 4;
      step(); step();
      check_reset_state();
      sel = 1;
      check_reset_state();
      rst_n = 1'b1;
      sel = 0;
      step();

      run_op(3'd0, 32'd1, 32'd1, 0);
      run_op(3'd0, 32'd2, 32'd1, 0);
      run_op(3'd0, 32'd4, 32'd2, 0);
      run_op(3'd0, 32'd8, 32'd1, 0);
      run_op(3'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
      run_op(3'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1);
      run_op(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run_op(3'd3, 32'd0, 32'd0, 0);
      run_op(3'd5, 32'h12345678, 32'h9ABCDEF0, 5);

      // reset after slices 0 and 1 have been written
      op = 3'd0; a = 32'hFFFFFFFF; b = 32'h0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      check("busy_before_reset", {62'd0, out_valid_m, in_ready_m}, 64'b00);
      rst_n = 1'b0;
      step();
      check_reset_state();
      rst_n = 1'b1;
      step();
      check("no_late_valid", 64'(out_valid_m), 64'd0);
      run_op(3'd6, 32'hFF00FF00, 32'hF0F0F0F0, 0);

      for (int i = 0; i < 20; i++)
         run_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));

      sel = 1; nchunk = 1;
      run_op(3'd0, 32'd1, 32'd1, 0);
      run_op(3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
      run_op(3'd7, 32'h5A5A5A5A, 32'hA5A5A5A5, 0);
      op = 3'd2; a = 32'h1; b = 32'h2; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      check_reset_state();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 20; i++)
         run_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
